// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared encodings for the RAM march-test controller.
//   - FSM state codes (IDLE, W0, RD, CMP, DONE)
//   - 2-bit phase codes for the four march phases
//   - per-phase lookup masks (bit i describes phase i) for address
//     direction, expected-data polarity, write-data polarity and CMP write enable
// Used by ram_bist_ctrl and ram_bist_addr_gen.
package ram_bist_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_W0   = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_CMP  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [1:0] PH_W0   = 2'd0;  // ascending, write PAT
  localparam logic [1:0] PH_RCW1 = 2'd1;  // ascending, expect PAT, write ~PAT
  localparam logic [1:0] PH_RCW2 = 2'd2;  // descending, expect ~PAT, write PAT
  localparam logic [1:0] PH_RC3  = 2'd3;  // ascending, expect PAT, no write

  // Bit i of each mask applies to phase i.
  localparam logic [3:0] PH_DOWN    = 4'b0100;  // 1 = descending address order
  localparam logic [3:0] PH_EXP_INV = 4'b0100;  // 1 = expect ~PAT on read
  localparam logic [3:0] PH_WR_INV  = 4'b0010;  // 1 = write ~PAT
  localparam logic [3:0] PH_CMP_WE  = 4'b0110;  // 1 = CMP state also writes

  // Select entry 'ph' of a per-phase mask.
  function automatic logic ph_sel(input logic [3:0] mask, input logic [1:0] ph);
    return mask[ph];
  endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// ram_bist_addr_gen: AW-bit up/down address counter for the march test.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (counter clears to 0)
//   load         load load_val this cycle (takes priority over en)
//   load_val     reload value (first address of the next phase)
//   en           step one address in the direction given by down
//   down         1 = count down, 0 = count up
//   addr         current address
//   tc           terminal count: addr is the last address for this direction
module ram_bist_addr_gen #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          en,
  input  logic          down,
  output logic [AW-1:0] addr,
  output logic          tc
);

  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] ZERO = '0;
  localparam logic [AW-1:0] TOP  = {AW{1'b1}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= ZERO;
    end else if (load) begin
      addr <= load_val;
    end else if (en) begin
      addr <= down ? (addr - ONE) : (addr + ONE);
    end
  end

  // The controller reloads at tc instead of stepping, so the counter never wraps inside a phase.
  assign tc = down ? (addr == ZERO) : (addr == TOP);

endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: march-test initiator for a single-port RAM with 1-cycle read latency.
// Sequence: W0 (write PAT ascending), then three read/compare phases
// (expect PAT / write ~PAT ascending, expect ~PAT / write PAT descending,
// expect PAT ascending without writes). Reports pass and the first failing
// address/data.
//
// Handshake: start is a request sampled only in IDLE; while busy=1 the
// controller owns the RAM port and further start pulses are ignored;
// done is a one-cycle completion pulse in which busy is already low, and
// pass/fail_addr/fail_data stay valid from done until the next accepted start.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (all outputs 0)
//   start                 begin test (IDLE only)
//   busy, done, pass      status / result
//   fail_addr, fail_data  first mismatch address and read data
//   ram_we, ram_addr, ram_din, ram_dout   RAM port
//   err_cnt               saturating mismatch count (RAM_BIST_ERRCNT_EN only)
//
// Build option RAM_BIST_ERRCNT_EN: when defined, the test always runs to the
// end and counts mismatches on err_cnt; when undefined, the first mismatch
// ends the test on the following cycle.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int              AW  = 8,
  parameter int              DW  = 8,
  parameter logic [DW-1:0]   PAT = 8'hAA
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_data,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
`ifdef RAM_BIST_ERRCNT_EN
  ,
  output logic [15:0]   err_cnt
`endif
);

  logic [2:0]    state, state_d;
  logic [1:0]    phase, phase_d;
  logic          err_seen;
  logic          mismatch;
  logic          abort;
  logic [DW-1:0] exp_data;
  logic [DW-1:0] wr_data;

  logic          cnt_load;
  logic [AW-1:0] cnt_load_val;
  logic          cnt_en;
  logic          cnt_down;
  logic [AW-1:0] cnt_addr;
  logic          cnt_tc;

  ram_bist_addr_gen #(.AW(AW)) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .down     (cnt_down),
    .addr     (cnt_addr),
    .tc       (cnt_tc)
  );

  assign cnt_down = ph_sel(PH_DOWN, phase);
  assign exp_data = ph_sel(PH_EXP_INV, phase) ? ~PAT : PAT;
  assign wr_data  = ph_sel(PH_WR_INV, phase) ? ~PAT : PAT;
  assign mismatch = (state == ST_CMP) && (ram_dout != exp_data);

`ifdef RAM_BIST_ERRCNT_EN
  assign abort = 1'b0;
`else
  // Stop on the first bad word; RAM contents are left as they are.
  assign abort = mismatch;
`endif

  always_comb begin
    state_d      = state;
    phase_d      = phase;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_W0;
          phase_d  = PH_W0;
          cnt_load = 1'b1;
        end
      end
      ST_W0: begin
        if (cnt_tc) begin
          state_d  = ST_RD;
          phase_d  = PH_RCW1;
          cnt_load = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RD: begin
        state_d = ST_CMP;
      end
      ST_CMP: begin
        if (abort) begin
          state_d = ST_DONE;
        end else if (cnt_tc) begin
          if (phase == PH_RC3) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_RD;
            phase_d  = phase + 2'd1;
            cnt_load = 1'b1;
          end
        end else begin
          state_d = ST_RD;
          cnt_en  = 1'b1;
        end
      end
      ST_DONE: begin
        // start seen here is dropped; only IDLE accepts a new test.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Reload value is the first address of whatever phase comes next.
    cnt_load_val = ph_sel(PH_DOWN, phase_d) ? {AW{1'b1}} : {AW{1'b0}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      phase     <= PH_W0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      err_seen  <= 1'b0;
`ifdef RAM_BIST_ERRCNT_EN
      err_cnt   <= 16'd0;
`endif
    end else begin
      state <= state_d;
      phase <= phase_d;
      if ((state == ST_IDLE) && start) begin
        pass      <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
        err_seen  <= 1'b0;
`ifdef RAM_BIST_ERRCNT_EN
        err_cnt   <= 16'd0;
`endif
      end
      if (mismatch) begin
        err_seen <= 1'b1;
        if (!err_seen) begin
          fail_addr <= cnt_addr;
          fail_data <= ram_dout;
        end
`ifdef RAM_BIST_ERRCNT_EN
        if (err_cnt != 16'hFFFF) begin
          err_cnt <= err_cnt + 16'd1;
        end
`endif
      end
      // Result is fixed on entry to DONE; the current cycle's compare counts too.
      if ((state_d == ST_DONE) && (state != ST_DONE)) begin
        pass <= !(err_seen || mismatch);
      end
    end
  end

  // Outputs decode straight from registered state so reset clears them at once.
  assign busy     = (state == ST_W0) || (state == ST_RD) || (state == ST_CMP);
  assign done     = (state == ST_DONE);
  assign ram_we   = (state == ST_W0) || ((state == ST_CMP) && ph_sel(PH_CMP_WE, phase));
  assign ram_addr = busy ? cnt_addr : '0;
  assign ram_din  = ram_we ? wr_data : '0;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: bench for ram_bist_ctrl (AW=8, DW=8, PAT=8'hAA) with a
// behavioural single-port RAM that can model bit0 of address 0x10 stuck at 0.
// Works with and without RAM_BIST_ERRCNT_EN.
module tb_ram_bist_ctrl;

  localparam int           AW  = 8;
  localparam int           DW  = 8;
  localparam logic [7:0]   PAT = 8'hAA;
  localparam int           CYC_LIMIT = 1850;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
`ifdef RAM_BIST_ERRCNT_EN
  logic [15:0]   err_cnt;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  bit            fault_on = 1'b0;
  logic [DW-1:0] mem [256];

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= (fault_on && ram_addr == 8'h10) ? (ram_din & 8'hFE) : ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  ram_bist_ctrl #(.AW(AW), .DW(DW), .PAT(PAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
`ifdef RAM_BIST_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         fault;
    int         rs1;
    int         rs2;
    int         exp_done;
    bit         exp_pass;
    logic [7:0] exp_faddr;
    logic [7:0] exp_fdata;
    logic [15:0] exp_ecnt;
  } vec_t;

  vec_t vecs[5];

  // ---------------- driver: one full test run ----------------
  task automatic run_vec(input vec_t v);
    int done_cnt = 0;
    int done_cyc = 0;
    int busy_cnt = 0;
    int we_p3 = 0;
    int busy_after = 0;
    logic [7:0] e;
    fault_on = v.fault;
    exp_q.delete();
    // Phase 2 visits each address twice (RD then CMP), from 0xFF down to 0x00.
    for (int a = 255; a >= 0; a--) begin
      exp_q.push_back(8'(a));
      exp_q.push_back(8'(a));
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= CYC_LIMIT; cyc++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
      if (done_cnt > 0 && !done && busy) busy_after++;
      if (cyc == 1) begin
        check("c1_busy", {31'd0, busy}, 32'd1);
        check("c1_we", {31'd0, ram_we}, 32'd1);
        check("c1_addr", {24'd0, ram_addr}, 32'd0);
        check("c1_din", {24'd0, ram_din}, {24'd0, PAT});
      end
      if (cyc == 258) begin
        check("p1_cmp_we", {31'd0, ram_we}, 32'd1);
        check("p1_cmp_din", {24'd0, ram_din}, {24'd0, ~PAT});
      end
      if (cyc >= 1281 && cyc <= 1792 && ram_we) we_p3++;
      if (cyc >= 769 && cyc <= 1280 && busy && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("p2_addr", {24'd0, ram_addr}, {24'd0, e});
      end
      start = (cyc == v.rs1) || (cyc == v.rs2);
      @(negedge clk);
    end
    start = 1'b0;
    check("done_count", done_cnt, 1);
    check("done_cycle", done_cyc, v.exp_done);
    check("busy_cycles", busy_cnt, v.exp_done - 1);
    check("busy_after_done", busy_after, 0);
    check("pass", {31'd0, pass}, {31'd0, v.exp_pass});
    check("fail_addr", {24'd0, fail_addr}, {24'd0, v.exp_faddr});
    check("fail_data", {24'd0, fail_data}, {24'd0, v.exp_fdata});
    if (v.exp_done == 1793) check("p3_writes", we_p3, 0);
`ifdef RAM_BIST_ERRCNT_EN
    check("err_cnt", {16'd0, err_cnt}, {16'd0, v.exp_ecnt});
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass}, 32'd0);
    check({tag, "_faddr"}, {24'd0, fail_addr}, 32'd0);
    check({tag, "_fdata"}, {24'd0, fail_data}, 32'd0);
    check({tag, "_we"}, {31'd0, ram_we}, 32'd0);
    check({tag, "_addr"}, {24'd0, ram_addr}, 32'd0);
    check({tag, "_din"}, {24'd0, ram_din}, 32'd0);
`ifdef RAM_BIST_ERRCNT_EN
    check({tag, "_ecnt"}, {16'd0, err_cnt}, 32'd0);
`endif
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int fault_done;
`ifdef RAM_BIST_ERRCNT_EN
    fault_done = 1793;
`else
    // Phase 2 starts at cycle 769 at 0xFF; the CMP of 0x10 is 2*(255-16)+1 later.
    fault_done = 1249;
`endif
    //          fault rs1  rs2   done        pass faddr  fdata  ecnt
    vecs[0] = '{1'b0, 0,   0,    1793,       1'b1, 8'h00, 8'h00, 16'd0};
    vecs[1] = '{1'b0, 5,   900,  1793,       1'b1, 8'h00, 8'h00, 16'd0};
    vecs[2] = '{1'b0, 0,   1793, 1793,       1'b1, 8'h00, 8'h00, 16'd0};
    vecs[3] = '{1'b1, 0,   0,    fault_done, 1'b0, 8'h10, 8'h54, 16'd1};
    vecs[4] = '{1'b0, 0,   0,    1793,       1'b1, 8'h00, 8'h00, 16'd0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i]);
    end

    // Reset during phase 2: outputs must clear without waiting for a clock edge.
    fault_on = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (1000) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    check("rst_hold_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
